// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared line geometry, refill FSM states and address helpers
package cache_pkg;

    localparam int ADDR_W         = 32;
    localparam int BYTE_W         = 8;
    localparam int WORDS_PER_LINE = 8;
    localparam int OFFSET_W       = $clog2(WORDS_PER_LINE);
    localparam int LINE_W         = BYTE_W * WORDS_PER_LINE;

    typedef enum logic [2:0] {
        IDLE,
        WB,
        FILL,
        DRAIN,
        RESP
    } refill_state_t;

    function automatic logic [ADDR_W-1:0] line_base(input logic [ADDR_W-1:0] addr);
        return {addr[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
    endfunction

endpackage

// File: rtl/cache_line_refill_engine_line_assembler.sv
// rtl/cache_line_refill_engine_line_assembler.sv - line register with whole-line load and per-byte slot writes
module line_assembler
    import cache_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr,
    input  logic                load,
    input  logic [LINE_W-1:0]   load_line,
    input  logic                we,
    input  logic [OFFSET_W-1:0] sel,
    input  logic [BYTE_W-1:0]   wdata,
    output logic [LINE_W-1:0]   line
);

    logic [LINE_W-1:0] line_q;

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            line_q <= '0;
        end else if (load) begin
            line_q <= load_line;
        end else if (we) begin
            line_q[int'(sel)*BYTE_W +: BYTE_W] <= wdata;
        end
    end

    assign line = line_q;

endmodule

// File: rtl/cache_line_refill_engine.sv
// rtl/cache_line_refill_engine.sv - miss engine: optional victim writeback then line fill; option CRITICAL_WORD_FIRST_EN
module cache_line_refill_engine
    import cache_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              req_wb,
    input  logic [ADDR_W-1:0] req_wb_addr,
    input  logic [LINE_W-1:0] req_wb_line,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [LINE_W-1:0] resp_line,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [BYTE_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [BYTE_W-1:0] mem_rdata
`ifdef CRITICAL_WORD_FIRST_EN
    ,
    output logic              crit_valid,
    output logic [BYTE_W-1:0] crit_data
`endif
);

    refill_state_t        state, state_nxt;
    logic [OFFSET_W-1:0]  beat_cnt;
    logic [ADDR_W-1:0]    fill_base_q;
    logic [ADDR_W-1:0]    wb_base_q;
    logic                 cap_q;
    logic [OFFSET_W-1:0]  cap_slot_q;
    logic [OFFSET_W-1:0]  fill_off;
    logic [LINE_W-1:0]    victim_line;
    logic [LINE_W-1:0]    fill_line;
    logic                 accept;
    logic                 last_beat;

    assign accept    = req_valid && (state == IDLE);
    assign last_beat = (beat_cnt == OFFSET_W'(WORDS_PER_LINE - 1));

`ifdef CRITICAL_WORD_FIRST_EN
    logic [OFFSET_W-1:0] start_off_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            start_off_q <= '0;
        end else if (accept) begin
            start_off_q <= req_addr[OFFSET_W-1:0];
        end
    end

    // Fill offset wraps mod line size, so slots still match beat addresses.
    assign fill_off   = beat_cnt + start_off_q;
    assign crit_valid = cap_q && (cap_slot_q == start_off_q);
    assign crit_data  = mem_rdata;
`else
    assign fill_off = beat_cnt;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            beat_cnt    <= '0;
            fill_base_q <= '0;
            wb_base_q   <= '0;
            cap_q       <= 1'b0;
            cap_slot_q  <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                beat_cnt    <= '0;
                fill_base_q <= line_base(req_addr);
                wb_base_q   <= line_base(req_wb_addr);
            end else if (state == WB || state == FILL) begin
                beat_cnt <= beat_cnt + OFFSET_W'(1);
            end
            // Registered memory: a fill beat's byte arrives one cycle after its address.
            cap_q      <= (state == FILL);
            cap_slot_q <= fill_off;
        end
    end

    always_comb begin
        state_nxt = state;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) state_nxt = req_wb ? WB : FILL;
            end
            WB: begin
                mem_we    = 1'b1;
                mem_addr  = wb_base_q | ADDR_W'(beat_cnt);
                mem_wdata = victim_line[int'(beat_cnt)*BYTE_W +: BYTE_W];
                if (last_beat) state_nxt = FILL;
            end
            FILL: begin
                mem_addr = fill_base_q | ADDR_W'(fill_off);
                if (last_beat) state_nxt = DRAIN;
            end
            DRAIN: state_nxt = RESP;
            RESP: begin
                if (resp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    line_assembler u_victim (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (1'b0),
        .load      (accept),
        .load_line (req_wb_line),
        .we        (1'b0),
        .sel       ('0),
        .wdata     ('0),
        .line      (victim_line)
    );

    line_assembler u_fill (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (accept),
        .load      (1'b0),
        .load_line ('0),
        .we        (cap_q),
        .sel       (cap_slot_q),
        .wdata     (mem_rdata),
        .line      (fill_line)
    );

    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);
    assign resp_line  = resp_valid ? fill_line : '0;

endmodule

// File: tb/tb_cache_line_refill_engine.sv
// tb/tb_cache_line_refill_engine.sv - self-checking bench with transaction-timeline model and byte memory
module tb_cache_line_refill_engine;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = '0;
    logic        req_wb = 1'b0;
    logic [31:0] req_wb_addr = '0;
    logic [63:0] req_wb_line = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [63:0] resp_line;
    logic [31:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_we;
    logic [7:0]  mem_rdata = '0;
`ifdef CRITICAL_WORD_FIRST_EN
    logic        crit_valid;
    logic [7:0]  crit_data;
`endif

    cache_line_refill_engine dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr    (req_addr),
        .req_wb      (req_wb),
        .req_wb_addr (req_wb_addr),
        .req_wb_line (req_wb_line),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_line   (resp_line),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_we      (mem_we),
        .mem_rdata   (mem_rdata)
`ifdef CRITICAL_WORD_FIRST_EN
        ,
        .crit_valid  (crit_valid),
        .crit_data   (crit_data)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Byte-wide memory: unwritten bytes read back as their own low address byte.
    logic [7:0] mem [int unsigned];

    always @(posedge clk) begin : mem_proc
        logic [7:0] rd;
        rd = mem.exists(mem_addr) ? mem[mem_addr] : mem_addr[7:0];
        if (mem_we === 1'b1) mem[mem_addr] = mem_wdata;
        mem_rdata <= rd;
    end

    // Model: outputs derived from cycles elapsed since the accepting edge.
    logic [7:0]  mm [int unsigned];
    int          cyc = 0;
    bit          started = 0;
    bit          m_busy = 0;
    int          m_t = 0;
    bit          m_wb = 0;
    logic [31:0] m_base = '0;
    logic [31:0] m_wbbase = '0;
    logic [2:0]  m_off = '0;
    logic [63:0] m_victim = '0;
    logic [63:0] m_line = '0;

    function automatic int fill_start(input bit wb);
        return wb ? 9 : 1;
    endfunction

    function automatic logic [7:0] mm_rd(input logic [31:0] a);
        return mm.exists(a) ? mm[a] : a[7:0];
    endfunction

    function automatic int beat_off(input int i);
`ifdef CRITICAL_WORD_FIRST_EN
        return (int'(m_off) + i) % 8;
`else
        return i;
`endif
    endfunction

    always @(posedge clk) begin : model_proc
        int d;
        d = cyc - m_t;
        if (m_busy && m_wb && d >= 1 && d <= 8)
            mm[m_wbbase + 32'(d - 1)] = m_victim[(d-1)*8 +: 8];
        if (!rst_n) begin
            started = 1;
            m_busy  = 0;
        end else if (m_busy) begin
            if (d >= fill_start(m_wb) + 9 && resp_ready) m_busy = 0;
        end else if (req_valid) begin
            m_busy   = 1;
            m_t      = cyc;
            m_wb     = req_wb;
            m_base   = req_addr & ~32'h7;
            m_wbbase = req_wb_addr & ~32'h7;
            m_off    = req_addr[2:0];
            m_victim = req_wb_line;
            for (int k = 0; k < 8; k++)
                m_line[k*8 +: 8] = (m_wb && m_wbbase == m_base) ? m_victim[k*8 +: 8]
                                                               : mm_rd(m_base + 32'(k));
        end
        cyc++;
    end

    always @(negedge clk) begin : compare_proc
        int d;
        int fs;
        bit e_we;
        logic [31:0] e_addr;
        logic [7:0] e_wd;
        bit e_rv;
        logic [63:0] e_line;
        bit e_crit;
        logic [7:0] e_cd;
        if (started) begin
            e_we = 0; e_addr = '0; e_wd = '0; e_rv = 0; e_line = '0; e_crit = 0; e_cd = '0;
            if (m_busy) begin
                d  = cyc - m_t;
                fs = fill_start(m_wb);
                if (m_wb && d >= 1 && d <= 8) begin
                    e_we   = 1;
                    e_addr = m_wbbase + 32'(d - 1);
                    e_wd   = m_victim[(d-1)*8 +: 8];
                end
                if (d >= fs && d < fs + 8) e_addr = m_base + 32'(beat_off(d - fs));
                if (d >= fs + 9) begin
                    e_rv   = 1;
                    e_line = m_line;
                end
                if (d == fs + 1) begin
                    e_crit = 1;
                    e_cd   = m_line[int'(m_off)*8 +: 8];
                end
            end
            chk("cyc_req_ready", req_ready, !m_busy);
            chk("cyc_mem_we", mem_we, e_we);
            chk("cyc_mem_addr", mem_addr, e_addr);
            chk("cyc_mem_wdata", mem_wdata, e_wd);
            chk("cyc_resp_valid", resp_valid, e_rv);
            chk("cyc_resp_line", resp_line, e_line);
`ifdef CRITICAL_WORD_FIRST_EN
            chk("cyc_crit_valid", crit_valid, e_crit);
            if (e_crit) chk("cyc_crit_data", crit_data, e_cd);
`else
            if (e_crit) e_cd = '0;
`endif
        end
    end

    int t_acc = 0;

    task automatic issue(input logic [31:0] a, input logic wb, input logic [31:0] wa,
                         input logic [63:0] wl);
        @(posedge clk);
        #1;
        req_addr    = a;
        req_wb      = wb;
        req_wb_addr = wa;
        req_wb_line = wl;
        req_valid   = 1'b1;
        @(posedge clk);
        #1;
        t_acc     = cyc - 1;
        req_valid = 1'b0;
    endtask

    task automatic wait_resp(output int lat);
        bit got;
        got = 0;
        lat = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (resp_valid === 1'b1) begin
                got = 1;
                lat = cyc - t_acc;
                break;
            end
        end
        if (!got) begin
            n_cmp++;
            n_fail++;
            $display("FAIL resp_timeout: got no resp_valid within 40 cycles");
        end
    endtask

    task automatic accept_resp();
        @(posedge clk);
        #1 resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
        @(negedge clk);
        chk("resp_back_to_idle", req_ready, 1'b1);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int lat;
        bit seen;
        logic [63:0] snap;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // 1: idle after reset
        seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (mem_we !== 1'b0) seen = 1;
        end
        chk("t1_mem_we_seen", seen, 1'b0);
        chk("t1_req_ready", req_ready, 1'b1);
        chk("t1_resp_valid", resp_valid, 1'b0);
        chk("t1_resp_line", resp_line, 64'h0);

        // 2: clean miss
        issue(32'h02001F86, 1'b0, 32'h0, 64'h0);
        @(negedge clk);
`ifdef CRITICAL_WORD_FIRST_EN
        chk("t2_first_addr", mem_addr, 32'h02001F86);
`else
        chk("t2_first_addr", mem_addr, 32'h02001F80);
`endif
        wait_resp(lat);
        chk("t2_latency", 64'(lat), 64'd10);
        chk("t2_line", resp_line, 64'h8786858483828180);
        accept_resp();

        // 3: dirty miss, fill of the same line sees written bytes
        issue(32'h00000043, 1'b1, 32'h00000045, 64'h0807060504030201);
        @(negedge clk);
        chk("t3_first_we", mem_we, 1'b1);
        chk("t3_first_addr", mem_addr, 32'h00000040);
        chk("t3_first_wdata", mem_wdata, 8'h01);
        wait_resp(lat);
        chk("t3_latency", 64'(lat), 64'd18);
        chk("t3_line", resp_line, 64'h0807060504030201);
        accept_resp();

        // 4: response backpressure with a competing request
        issue(32'h00001234, 1'b0, 32'h0, 64'h0);
        wait_resp(lat);
        chk("t4_latency", 64'(lat), 64'd10);
        chk("t4_line", resp_line, 64'h3736353433323130);
        snap = resp_line;
        req_valid = 1'b1;
        req_addr  = 32'h00005000;
        req_wb    = 1'b0;
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (resp_line !== snap || req_ready !== 1'b0 || mem_we !== 1'b0 ||
                resp_valid !== 1'b1) seen = 1;
        end
        chk("t4_hold_disturbed", seen, 1'b0);
        req_valid = 1'b0;
        accept_resp();

        // 5: reset in the middle of a writeback
        issue(32'h000005C0, 1'b1, 32'h00000300, 64'hA8A7A6A5A4A3A2A1);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("t5_mem_we_after_rst", mem_we, 1'b0);
        chk("t5_req_ready_after_rst", req_ready, 1'b1);
        chk("t5_resp_valid_after_rst", resp_valid, 1'b0);
        issue(32'h00000302, 1'b0, 32'h0, 64'h0);
        wait_resp(lat);
        chk("t5_latency", 64'(lat), 64'd10);
        chk("t5_line", resp_line, 64'h07060504A4A3A2A1);
        accept_resp();

`ifdef CRITICAL_WORD_FIRST_EN
        // 6: critical word first
        issue(32'h02001F85, 1'b0, 32'h0, 64'h0);
        @(negedge clk);
        chk("t6_first_addr", mem_addr, 32'h02001F85);
        @(negedge clk);
        chk("t6_crit_valid", crit_valid, 1'b1);
        chk("t6_crit_data", crit_data, 8'h85);
        wait_resp(lat);
        chk("t6_latency", 64'(lat), 64'd10);
        chk("t6_line", resp_line, 64'h8786858483828180);
        accept_resp();
`endif

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
